pot_fire_manager: RTL

- Parametrised cooking and fire engine for N stove stations on the top counter row.
- Replaces the hard-wired single-pot fire FSM. Generalised over pot count, cook, burn and spread times, and row length.
- Adds per-pot timers, neighbour fire spread with its own timer, per-cell extinguishing, and fire capture of cooking pots.
- Sits beside the action block: action sends place/remove/extinguish events; this block returns pot status, timers and the fire row for the grid and renderer.

---
 rtl/pot_fire_manager.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pot_fire_manager.sv
// Cooking and fire engine for NUM_POTS stove stations on the top counter row.
// Optional burn-warning outputs are built when POT_BURN_WARN_EN is defined.
module pot_fire_manager #(
    parameter int NUM_POTS      = 4,
    parameter int ROW_LEN       = 13,
    parameter int POT_COL0      = 8,
    parameter int CNT_W         = 11,
    parameter int COOK_FRAMES   = 600,
    parameter int BURN_FRAMES   = 600,
    parameter int SPREAD_FRAMES = 300,
    parameter int WARN_FRAMES   = 180
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic [NUM_POTS-1:0]       place_raw,
    input  logic [NUM_POTS-1:0]       remove,
    input  logic [ROW_LEN-1:0]        extinguish,
    output logic [NUM_POTS*2-1:0]     pot_status,
    output logic [NUM_POTS*CNT_W-1:0] time_left,
    output logic [ROW_LEN-1:0]        fire_row,
    output logic [NUM_POTS-1:0]       cooked_pulse,
    output logic                      fire_alarm,
    output logic [NUM_POTS-1:0]       burn_warn
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COOKING = 2'd1,
        ST_DONE    = 2'd2,
        ST_FIRE    = 2'd3
    } pot_state_t;

    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] COOK_LOAD   = CNT_W'(COOK_FRAMES);
    localparam logic [CNT_W-1:0] BURN_LOAD   = CNT_W'(BURN_FRAMES);
    localparam logic [CNT_W-1:0] SPREAD_LAST = CNT_W'(SPREAD_FRAMES - 1);

    if (POT_COL0 + NUM_POTS > ROW_LEN) begin : g_bad_pot_col
        $error("pot_fire_manager: stations extend past the end of the row");
    end
    if (WARN_FRAMES < 0 || WARN_FRAMES >= (1 << CNT_W)) begin : g_bad_warn
        $error("pot_fire_manager: WARN_FRAMES does not fit the timer width");
    end

    pot_state_t           state_p0 [NUM_POTS];
    logic [CNT_W-1:0]     cnt_p0   [NUM_POTS];
    logic [CNT_W-1:0]     spread_cnt_p0;

    pot_state_t           state_d  [NUM_POTS];
    logic [CNT_W-1:0]     cnt_d    [NUM_POTS];
    logic [NUM_POTS-1:0]  cooked_d;
    logic [NUM_POTS-1:0]  ignite_d;
    logic [ROW_LEN-1:0]   ignite_row;
    logic [ROW_LEN-1:0]   fire_d;
    logic [CNT_W-1:0]     spread_cnt_d;
    logic                 spread_step;

    function automatic logic [ROW_LEN-1:0] spread_row(input logic [ROW_LEN-1:0] row);
        return row | (row << 1) | (row >> 1);
    endfunction

    // Per-pot next state: fire capture outranks remove, which outranks the timer.
    always_comb begin
        for (int i = 0; i < NUM_POTS; i++) begin
            state_d[i]  = state_p0[i];
            cnt_d[i]    = cnt_p0[i];
            cooked_d[i] = 1'b0;
            ignite_d[i] = 1'b0;
            unique case (state_p0[i])
                ST_IDLE: begin
                    if (place_raw[i]) begin
                        state_d[i] = ST_COOKING;
                        cnt_d[i]   = COOK_LOAD;
                    end
                end
                ST_COOKING: begin
                    if (fire_row[POT_COL0+i]) begin
                        state_d[i] = ST_FIRE;
                        cnt_d[i]   = '0;
                    end else if (remove[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (frame_tick) begin
                        if (cnt_p0[i] == ONE) begin
                            state_d[i]  = ST_DONE;
                            cnt_d[i]    = BURN_LOAD;
                            cooked_d[i] = 1'b1;
                        end else if (cnt_p0[i] != '0) begin
                            cnt_d[i] = cnt_p0[i] - ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (fire_row[POT_COL0+i]) begin
                        state_d[i] = ST_FIRE;
                        cnt_d[i]   = '0;
                    end else if (remove[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (frame_tick) begin
                        if (cnt_p0[i] == ONE) begin
                            state_d[i]  = ST_FIRE;
                            cnt_d[i]    = '0;
                            ignite_d[i] = 1'b1;
                        end else if (cnt_p0[i] != '0) begin
                            cnt_d[i] = cnt_p0[i] - ONE;
                        end
                    end
                end
                ST_FIRE: begin
                    if (!fire_row[POT_COL0+i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Fire row: spread on the timer, add new ignitions, then spray wins over both.
    always_comb begin
        ignite_row   = '0;
        spread_step  = 1'b0;
        spread_cnt_d = spread_cnt_p0;
        for (int i = 0; i < NUM_POTS; i++) begin
            ignite_row[POT_COL0+i] = ignite_d[i];
        end
        if (fire_row == '0) begin
            spread_cnt_d = '0;
        end else if (fire_alarm && frame_tick) begin
            if (spread_cnt_p0 == SPREAD_LAST) begin
                spread_step  = 1'b1;
                spread_cnt_d = '0;
            end else begin
                spread_cnt_d = spread_cnt_p0 + ONE;
            end
        end
        fire_d = ((spread_step ? spread_row(fire_row) : fire_row) | ignite_row) & ~extinguish;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_POTS; i++) begin
                state_p0[i] <= ST_IDLE;
                cnt_p0[i]   <= '0;
            end
            spread_cnt_p0 <= '0;
            fire_row      <= '0;
            cooked_pulse  <= '0;
            fire_alarm    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_POTS; i++) begin
                state_p0[i] <= state_d[i];
                cnt_p0[i]   <= cnt_d[i];
            end
            spread_cnt_p0 <= spread_cnt_d;
            fire_row      <= fire_d;
            cooked_pulse  <= cooked_d;
            fire_alarm    <= |fire_row;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_POTS; i++) begin
            pot_status[2*i +: 2]       = state_p0[i];
            time_left[CNT_W*i +: CNT_W] = cnt_p0[i];
        end
    end

`ifdef POT_BURN_WARN_EN
    localparam logic [CNT_W-1:0] WARN_LOAD = CNT_W'(WARN_FRAMES);
    logic [NUM_POTS-1:0] warn_d;

    always_comb begin
        for (int i = 0; i < NUM_POTS; i++) begin
            warn_d[i] = (state_d[i] == ST_DONE) && (cnt_d[i] <= WARN_LOAD);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burn_warn <= '0;
        end else begin
            burn_warn <= warn_d;
        end
    end
`else
    assign burn_warn = '0;
`endif

endmodule
